// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-light controller front end.
package traffic_pkg;

  localparam int NUM_LANES    = 8;
  localparam int LANE_COUNT_W = 8;
  localparam int CAR_TOTAL_W  = 11;

  typedef logic [LANE_COUNT_W-1:0]                  lane_count_t;
  typedef logic [NUM_LANES-1:0][LANE_COUNT_W-1:0]   lane_vec_t;

endpackage

// File: rtl/lane_counter_slice.sv
// One lane: sensor synchronizer, rising-edge detect, green-time departure
// timer and a saturating occupancy counter.
module lane_counter_slice
  import traffic_pkg::*;
#(
  parameter int COUNT_W       = LANE_COUNT_W,
  parameter int DEPART_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arrive,
  input  logic               green,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               depart_pulse
);

  // A 1-cycle discharge rate still needs a 1-bit timer to keep widths legal.
  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0]      T_LAST  = TW'(DEPART_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic               s1, s2, s3;
  logic               rise, active, depart;
  logic [TW-1:0]      timer;
  logic [COUNT_W-1:0] cnt_nxt;

  assign rise   = s2 & ~s3;
  assign active = green && (count != '0);
  assign depart = active && (timer == T_LAST);

  // Two-flop synchronizer plus previous-value flop for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= arrive;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Timer runs only while continuously green with cars waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   timer <= '0;
    else if (!active || depart) timer <= '0;
    else                       timer <= timer + TW'(1);
  end

  // Next count: arrival and departure in the same cycle cancel out.
  always_comb begin
    cnt_nxt = count;
    if (rise && !depart && (count != CNT_MAX)) cnt_nxt = count + COUNT_W'(1);
    else if (depart && !rise)                  cnt_nxt = count - COUNT_W'(1);
  end

  // Count, full flag and departure pulse all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      depart_pulse <= 1'b0;
    end else begin
      count        <= cnt_nxt;
      full         <= (cnt_nxt == CNT_MAX);
      depart_pulse <= depart;
    end
  end

endmodule

// File: rtl/lane_traffic_counter.sv
// Eight independent lane occupancy counters plus the total car count used
// by the day-time arbiter. Lane order: N1,N2,E1,E2,S1,S2,W1,W2.
module lane_traffic_counter
  import traffic_pkg::*;
#(
  parameter int LANES         = NUM_LANES,
  parameter int COUNT_W       = LANE_COUNT_W,
  parameter int DEPART_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       arrive,
  input  logic [LANES-1:0]       laneOutput,
  output lane_vec_t              lane,
  output logic [LANES-1:0]       laneFull,
  output logic [LANES-1:0]       departPulse,
  output logic [CAR_TOTAL_W-1:0] carTotal
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_counter_slice #(
      .COUNT_W       (COUNT_W),
      .DEPART_CYCLES (DEPART_CYCLES)
    ) u_slice (
      .clk          (clk),
      .rst          (rst),
      .arrive       (arrive[g]),
      .green        (laneOutput[g]),
      .count        (lane[g]),
      .full         (laneFull[g]),
      .depart_pulse (departPulse[g])
    );
  end

  // Sum of all lane counts; 11 bits holds 8 x 255 without overflow.
  always_comb begin
    carTotal = '0;
    for (int i = 0; i < LANES; i++) carTotal += CAR_TOTAL_W'(lane[i]);
  end

endmodule

// File: tb/tb_lane_traffic_counter.sv
// Directed bench for lane_traffic_counter with hand-computed expectations.
module tb_lane_traffic_counter;
  import traffic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  arrive, laneOutput;
  lane_vec_t   lane, ev;
  logic [7:0]  laneFull, departPulse;
  logic [10:0] carTotal;

  int nvec = 0;
  int nerr = 0;

  lane_traffic_counter dut (
    .clk         (clk),
    .rst         (rst),
    .arrive      (arrive),
    .laneOutput  (laneOutput),
    .lane        (lane),
    .laneFull    (laneFull),
    .departPulse (departPulse),
    .carTotal    (carTotal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle-high, one-cycle-low sensor pulse on the masked lanes.
  task automatic pulses(input logic [7:0] m);
    arrive = m;
    tick(1);
    arrive = 8'h00;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; arrive = 8'h00; laneOutput = 8'h00;
    tick(2);
    chk("rst_lane",   64'(lane), 64'h0);
    chk("rst_full",   64'(laneFull), 64'h0);
    chk("rst_depart", 64'(departPulse), 64'h0);
    chk("rst_total",  64'(carTotal), 64'h0);
    rst = 1'b0;

    // Arrival latency: increment lands on the third edge.
    arrive = 8'h04;
    tick(2);
    chk("lat_early", 64'(lane), 64'h0);
    tick(1);
    arrive = 8'h00;
    ev = '0; ev[2] = 8'd1;
    chk("lat_lane", 64'(lane), 64'(ev));
    chk("lat_total", 64'(carTotal), 64'd1);

    // Held sensor counts once, then rearms after going low.
    arrive = 8'h01;
    tick(20);
    ev[0] = 8'd1;
    chk("held_once", 64'(lane), 64'(ev));
    arrive = 8'h00;
    tick(2);
    arrive = 8'h01;
    tick(5);
    ev[0] = 8'd2;
    chk("rearm", 64'(lane), 64'(ev));
    arrive = 8'h00;
    tick(3);

    // Departure rate on lane 4 (lane 5 green but empty).
    repeat (3) pulses(8'h10);
    tick(3);
    ev[4] = 8'd3;
    chk("pre4", 64'(lane), 64'(ev));
    laneOutput = 8'b0011_0000;
    for (int c = 1; c <= 13; c++) begin
      tick(1);
      chk("dep4_pulse", 64'(departPulse), (c % 4 == 0) ? 64'h10 : 64'h0);
      chk("dep4_cnt",   64'(lane[4]), 64'(3 - c / 4));
    end
    tick(6);
    chk("dep4_idle", 64'(departPulse), 64'h0);
    laneOutput = 8'h00;
    ev[4] = 8'd0;

    // Interrupted green on lane 6: only an unbroken 4-cycle window departs.
    repeat (2) pulses(8'h40);
    tick(3);
    ev[6] = 8'd2;
    chk("pre6", 64'(lane), 64'(ev));
    laneOutput = 8'h40;
    tick(3);
    laneOutput = 8'h00;
    tick(1);
    chk("int_red_cnt", 64'(lane[6]), 64'd2);
    laneOutput = 8'h40;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      chk("int_pulse", 64'(departPulse), (c == 4) ? 64'h40 : 64'h0);
    end
    laneOutput = 8'h00;
    ev[6] = 8'd1;
    chk("int_cnt", 64'(lane), 64'(ev));

    // Saturation on lane 1.
    repeat (254) pulses(8'h02);
    tick(3);
    chk("sat254_cnt",  64'(lane[1]), 64'd254);
    chk("sat254_full", 64'(laneFull), 64'h0);
    pulses(8'h02);
    tick(3);
    chk("sat255_cnt",  64'(lane[1]), 64'd255);
    chk("sat255_full", 64'(laneFull), 64'h02);
    pulses(8'h02);
    tick(3);
    chk("sat256_cnt",  64'(lane[1]), 64'd255);
    chk("sat256_full", 64'(laneFull), 64'h02);
    chk("sat_total",   64'(carTotal), 64'd259);

    // Rise and depart coincide on lane 1: count holds, pulse still fires.
    laneOutput = 8'h02;
    tick(1);
    arrive = 8'h02;
    tick(1);
    arrive = 8'h00;
    tick(1);
    chk("sim_pre_pulse", 64'(departPulse), 64'h0);
    tick(1);
    laneOutput = 8'h00;
    chk("sim_cnt",   64'(lane[1]), 64'd255);
    chk("sim_pulse", 64'(departPulse), 64'h02);
    chk("sim_full",  64'(laneFull), 64'h02);
    tick(1);
    chk("sim_pulse_end", 64'(departPulse), 64'h0);

    // Async reset mid-count.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int r = 0; r < 9; r++) begin
      logic [7:0] m;
      m = 8'h80;
      if (r < 5) m[0] = 1'b1;
      if (r < 7) m[2] = 1'b1;
      if (r < 1) m[4] = 1'b1;
      pulses(m);
    end
    tick(3);
    ev = '0; ev[0] = 8'd5; ev[2] = 8'd7; ev[4] = 8'd1; ev[7] = 8'd9;
    chk("load", 64'(lane), 64'(ev));
    chk("load_total", 64'(carTotal), 64'd22);
    laneOutput = 8'h0C;
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_lane",   64'(lane), 64'h0);
    chk("arst_full",   64'(laneFull), 64'h0);
    chk("arst_depart", 64'(departPulse), 64'h0);
    chk("arst_total",  64'(carTotal), 64'h0);
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk("post_rst", 64'({departPulse, lane}), 64'h0);
    end
    laneOutput = 8'h00;

    // Sensor already high across reset release counts once.
    rst = 1'b1;
    arrive = 8'h08;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rel_early", 64'(lane[3]), 64'd0);
    tick(1);
    chk("rel_cnt", 64'(lane[3]), 64'd1);
    tick(4);
    chk("rel_hold", 64'(lane[3]), 64'd1);
    arrive = 8'h00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
